// File: rtl/fir_stim_src.sv
// FIR stimulus source: buffers (sample, golden) pairs and replays them
// to the filter and its checker over the next/ready handshake.
module fir_stim_src #(
    parameter int W     = 32,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stop,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [W-1:0]           load_in,
    input  logic [W-1:0]           load_gold,
    input  logic                   start,
    input  logic                   next,
    output logic [W-1:0]           in_sample,
    input  logic                   fir_ready,
    output logic [W-1:0]           gold_out,
    output logic                   gold_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t FULL = ptr_t'(DEPTH);
    localparam ptr_t ONE  = ptr_t'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_t;

    state_t         state_q, state_d;
    ptr_t           wr_q, wr_d;
    ptr_t           rs_q, rs_d;
    ptr_t           rg_q, rg_d;
    logic [W-1:0]   ins_q, ins_d;
    logic [W-1:0]   gout_q, gout_d;
    logic           gval_q, gval_d;
    logic           und_q, und_d;

    logic [W-1:0]   samp_mem [DEPTH];
    logic [W-1:0]   gold_mem [DEPTH];

    ptr_t           rs_nx;
    ptr_t           rg_nx;
    logic           wr_en;

    assign count      = wr_q - rg_q;
    assign load_ready = ((state_q == IDLE) || (state_q == LOAD)) && (count < FULL);
    assign wr_en      = load_valid && load_ready && !stop;
    assign rs_nx      = rs_q + ONE;
    assign rg_nx      = rg_q + ONE;

    assign in_sample  = ins_q;
    assign gold_out   = gout_q;
    assign gold_valid = gval_q;
    assign underrun   = und_q;
    assign busy       = (state_q == STREAM);
    assign done       = (state_q == DONE);

    // Storage is deliberately left out of reset; stale entries are never read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            samp_mem[wr_q[AW-1:0]] <= load_in;
            gold_mem[wr_q[AW-1:0]] <= load_gold;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rs_d    = rs_q;
        rg_d    = rg_q;
        ins_d   = ins_q;
        gout_d  = gout_q;
        gval_d  = 1'b0;
        und_d   = und_q;
        if (stop) begin
            state_d = IDLE;
            wr_d    = '0;
            rs_d    = '0;
            rg_d    = '0;
            ins_d   = '0;
            gout_d  = '0;
            und_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        wr_d    = wr_q + ONE;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (wr_en) wr_d = wr_q + ONE;
                    if (start && (count != '0)) begin
                        state_d = STREAM;
                        rs_d    = '0;
                        rg_d    = '0;
                        ins_d   = samp_mem[0];
                    end
                end
                STREAM: begin
                    if (next) begin
                        if (rs_nx < wr_q) begin
                            rs_d  = rs_nx;
                            ins_d = samp_mem[rs_nx[AW-1:0]];
                        end else begin
                            rs_d  = wr_q;
                            ins_d = '0;
                            und_d = 1'b1;
                        end
                    end
                    if (fir_ready) begin
                        if (rg_q < wr_q) begin
                            gout_d = gold_mem[rg_q[AW-1:0]];
                            gval_d = 1'b1;
                            rg_d   = rg_nx;
                            if (rg_nx == wr_q) state_d = DONE;
                        end else begin
                            und_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rs_q    <= '0;
            rg_q    <= '0;
            ins_q   <= '0;
            gout_q  <= '0;
            gval_q  <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rs_q    <= rs_d;
            rg_q    <= rg_d;
            ins_q   <= ins_d;
            gout_q  <= gout_d;
            gval_q  <= gval_d;
            und_q   <= und_d;
        end
    end

endmodule

// File: tb/tb_fir_stim_src.sv
// Bench for fir_stim_src: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based model.
module tb_fir_stim_src;

    localparam int W     = 32;
    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stop = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [W-1:0]  load_in = '0;
    logic [W-1:0]  load_gold = '0;
    logic          start = 1'b0;
    logic          next = 1'b0;
    logic [W-1:0]  in_sample;
    logic          fir_ready = 1'b0;
    logic [W-1:0]  gold_out;
    logic          gold_valid;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;
    logic          underrun;

    fir_stim_src #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stop(stop),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_in(load_in), .load_gold(load_gold),
        .start(start), .next(next), .in_sample(in_sample),
        .fir_ready(fir_ready), .gold_out(gold_out),
        .gold_valid(gold_valid), .count(count),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 loading, 2 streaming, 3 finished.
    int           m_phase;
    logic [W-1:0] m_samp[$];
    logic [W-1:0] m_gold[$];
    int           m_used;
    int           m_rel;
    logic [W-1:0] m_in, m_gout;
    bit           m_gval, m_und;

    function automatic int m_count();
        return m_samp.size() - m_rel;
    endfunction

    task automatic model_clear();
        m_phase = 0;
        m_samp.delete();
        m_gold.delete();
        m_used = 0;
        m_rel  = 0;
        m_in   = '0;
        m_gout = '0;
        m_gval = 0;
        m_und  = 0;
    endtask

    task automatic model_step();
        int  cnt;
        bit  can_load;
        cnt      = m_count();
        can_load = (m_phase < 2) && (cnt < DEPTH);
        if (!rst_n || stop) begin
            model_clear();
            return;
        end
        m_gval = 0;
        if (m_phase < 2 && load_valid && can_load) begin
            m_samp.push_back(load_in);
            m_gold.push_back(load_gold);
        end
        if (m_phase == 0) begin
            if (m_samp.size() > 0) m_phase = 1;
        end else if (m_phase == 1) begin
            if (start && cnt > 0) begin
                m_phase = 2;
                m_used  = 0;
                m_rel   = 0;
                m_in    = m_samp[0];
            end
        end else if (m_phase == 2) begin
            if (next) begin
                if (m_used + 1 < m_samp.size()) begin
                    m_used++;
                    m_in = m_samp[m_used];
                end else begin
                    m_used = m_samp.size();
                    m_in   = '0;
                    m_und  = 1;
                end
            end
            if (fir_ready) begin
                if (m_rel < m_gold.size()) begin
                    m_gout = m_gold[m_rel];
                    m_gval = 1;
                    m_rel++;
                    if (m_rel == m_gold.size()) m_phase = 3;
                end else begin
                    m_und = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("in_sample", 64'(in_sample), 64'(m_in));
        chk("gold_out", 64'(gold_out), 64'(m_gout));
        chk("gold_valid", 64'(gold_valid), 64'(m_gval));
        chk("count", 64'(count), 64'(m_count()));
        chk("load_ready", 64'(load_ready), 64'((m_phase < 2) && (m_count() < DEPTH)));
        chk("busy", 64'(busy), 64'(m_phase == 2));
        chk("done", 64'(done), 64'(m_phase == 3));
        chk("underrun", 64'(underrun), 64'(m_und));
    endtask

    task automatic cyc(input bit lv, input logic [W-1:0] li, input logic [W-1:0] lg,
                       input bit st, input bit nx, input bit fr, input bit sp);
        load_valid = lv;
        load_in    = li;
        load_gold  = lg;
        start      = st;
        next       = nx;
        fir_ready  = fr;
        stop       = sp;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic do_stop();
        cyc(0, '0, '0, 0, 0, 0, 1);
    endtask

    task automatic load4();
        for (int i = 1; i <= 4; i++) cyc(1, W'(i), W'(10 * i), 0, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        #2;
        check_all();
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        #5 rst_n = 1'b1;
        idle();

        // Sequential sample advance
        do_stop();
        load4();
        cyc(0, '0, '0, 1, 0, 0, 0);
        chk("start_in", 64'(in_sample), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            cyc(0, '0, '0, 0, 1, 0, 0);
            chk("next_in", 64'(in_sample), 64'(i));
            chk("next_count", 64'(count), 64'd4);
        end

        // Golden release with gaps
        do_stop();
        load4();
        cyc(0, '0, '0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, '0, '0, 0, 0, 1, 0);
            chk("gold_val", 64'(gold_out), 64'(10 * i));
            chk("gold_vld", 64'(gold_valid), 64'd1);
            chk("gold_done", 64'(done), 64'(i == 4));
            idle();
            chk("gold_pulse", 64'(gold_valid), 64'd0);
        end
        chk("final_busy", 64'(busy), 64'd0);

        // Full buffer
        do_stop();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, $urandom, $urandom, 0, 0, 0, 0);
            chk("fill_ready", 64'(load_ready), 64'(i < DEPTH - 1));
        end
        cyc(1, 32'hdead, 32'hbeef, 0, 0, 0, 0);
        chk("full_count", 64'(count), 64'(DEPTH));

        // Underrun on exhausted samples
        do_stop();
        cyc(1, 32'h11, 32'h111, 0, 0, 0, 0);
        cyc(1, 32'h22, 32'h222, 0, 0, 0, 0);
        cyc(0, '0, '0, 1, 0, 0, 0);
        cyc(0, '0, '0, 0, 1, 0, 0);
        chk("und_in2", 64'(in_sample), 64'h22);
        cyc(0, '0, '0, 0, 1, 0, 0);
        chk("und_in0", 64'(in_sample), 64'd0);
        chk("und_set", 64'(underrun), 64'd1);
        cyc(0, '0, '0, 0, 1, 0, 0);
        idle();
        chk("und_sticky", 64'(underrun), 64'd1);
        do_stop();
        chk("und_clr", 64'(underrun), 64'd0);

        // Concurrent next and fir_ready
        load4();
        cyc(0, '0, '0, 1, 0, 0, 0);
        cyc(0, '0, '0, 0, 1, 1, 0);
        chk("both_in", 64'(in_sample), 64'd2);
        chk("both_gv", 64'(gold_valid), 64'd1);
        chk("both_go", 64'(gold_out), 64'd10);

        // Async reset mid-stream
        cyc(0, '0, '0, 0, 1, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        chk("arst_busy", 64'(busy), 64'd0);
        #2 rst_n = 1'b1;
        cyc(0, '0, '0, 1, 0, 0, 0);
        chk("arst_start", 64'(busy), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 1) == 1), $urandom, $urandom,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4),
                ($urandom_range(0, 9) < 4), ($urandom_range(0, 79) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
